mem_handshake_responder: RTL and testbench

- Byte-addressed data memory with a req/ack handshake; the responder side of the CPU memory port.
- Replaces the fixed-timing memory so the datapath and control unit can be exercised against configurable wait states.
- Supports byte-lane writes, so SB/SH/SW arrive as word data plus a lane mask.
- A single outstanding transaction at a time.

---
 rtl/mem_handshake_responder.sv | 124 ++++++++++++
 tb/tb_mem_handshake_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_handshake_responder.sv
// Byte-addressed data memory with a req/ack handshake and configurable wait states.
// One transaction in flight at a time; little-endian lanes wrap at the top of memory.
`timescale 1ns/1ps
module mem_handshake_responder #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        busy
);

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mem_handshake_responder: LATENCY must be within 1..15");
   end

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state, state_next;
   logic [3:0]          cnt, cnt_next;
   logic                capture, commit;

   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [3:0]          be_q;

   logic [7:0]          mem [0:(1 << ADDR_W) - 1];
   logic [ADDR_W-1:0]   lane_addr [4];
   logic [31:0]         rd_word;

   logic                unused_addr_hi;
   assign unused_addr_hi = ^addr[31:ADDR_W];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      capture    = 1'b0;
      commit     = 1'b0;
      busy       = 1'b0;
      ack        = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               capture    = 1'b1;
               cnt_next   = 4'(LATENCY - 1);
               state_next = WAIT;
            end
         end
         WAIT: begin
            busy = 1'b1;
            if (cnt != '0) begin
               cnt_next = cnt - 4'd1;
            end else begin
               commit     = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            ack        = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata   <= '0;
      end else begin
         if (capture) begin
            we_q    <= we;
            addr_q  <= addr[ADDR_W-1:0];
            wdata_q <= wdata;
            be_q    <= be;
         end
         if (commit && !we_q) begin
            rdata <= rd_word;
         end
      end
   end

   // Lane addresses wrap naturally in ADDR_W bits, giving the top-of-memory rollover.
   always_comb begin
      rd_word = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         lane_addr[i]      = addr_q + ADDR_W'(i);
         rd_word[8*i +: 8] = mem[lane_addr[i]];
      end
   end

   // Array is deliberately left out of reset; commit cannot fire while reset holds the FSM in IDLE.
   always_ff @(posedge clk) begin
      if (commit && we_q) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be_q[i]) begin
               mem[lane_addr[i]] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_handshake_responder.sv
// Directed bench for mem_handshake_responder: three instances at LATENCY 1, 2 and 3.
`timescale 1ns/1ps
module tb_mem_handshake_responder;

   logic        clk;
   logic        reset;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        req1, req2, req3;
   logic [31:0] rdata1, rdata2, rdata3;
   logic        ack1, ack2, ack3;
   logic        busy1, busy2, busy3;

   int tests = 0;
   int fails = 0;
   logic [31:0] last_rd [1:3];

   mem_handshake_responder #(.ADDR_W(8), .LATENCY(1)) u1 (
      .clk(clk), .reset(reset), .req(req1), .we(we), .addr(addr), .wdata(wdata),
      .be(be), .rdata(rdata1), .ack(ack1), .busy(busy1));
   mem_handshake_responder #(.ADDR_W(8), .LATENCY(2)) u2 (
      .clk(clk), .reset(reset), .req(req2), .we(we), .addr(addr), .wdata(wdata),
      .be(be), .rdata(rdata2), .ack(ack2), .busy(busy2));
   mem_handshake_responder #(.ADDR_W(8), .LATENCY(3)) u3 (
      .clk(clk), .reset(reset), .req(req3), .we(we), .addr(addr), .wdata(wdata),
      .be(be), .rdata(rdata3), .ack(ack3), .busy(busy3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s/%s observed=%h expected=%h", tag, what, obs, exp);
      end
   endtask

   function automatic logic [31:0] rdv(input int sel);
      case (sel)
         1:       return rdata1;
         2:       return rdata2;
         default: return rdata3;
      endcase
   endfunction

   function automatic logic [31:0] ackv(input int sel);
      case (sel)
         1:       return {31'b0, ack1};
         2:       return {31'b0, ack2};
         default: return {31'b0, ack3};
      endcase
   endfunction

   function automatic logic [31:0] busyv(input int sel);
      case (sel)
         1:       return {31'b0, busy1};
         2:       return {31'b0, busy2};
         default: return {31'b0, busy3};
      endcase
   endfunction

   task automatic set_req(input int sel, input logic v);
      case (sel)
         1:       req1 = v;
         2:       req2 = v;
         default: req3 = v;
      endcase
   endtask

   task automatic perturb_inputs();
      addr  = addr ^ 32'h0000_005A;
      we    = ~we;
      wdata = ~wdata;
      be    = ~be;
   endtask

   // One full transaction with cycle-exact checks of busy/ack/rdata.
   task automatic txn(input int sel, input int lat, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b, input logic [31:0] exp_rd,
                      input logic [31:0] mask, input bit perturb, input string tag);
      logic [31:0] exp_word;
      exp_word = w ? last_rd[sel] : exp_rd;
      @(negedge clk);
      we = w; addr = a; wdata = d; be = b;
      set_req(sel, 1'b1);
      @(posedge clk); #1;
      set_req(sel, 1'b0);
      check(tag, "busy_e0", busyv(sel), 32'd1);
      check(tag, "ack_e0", ackv(sel), 32'd0);
      for (int k = 1; k <= lat; k++) begin
         if (perturb) perturb_inputs();
         @(posedge clk); #1;
         if (k < lat) begin
            check(tag, "busy_wait", busyv(sel), 32'd1);
            check(tag, "ack_wait", ackv(sel), 32'd0);
         end else begin
            check(tag, "ack", ackv(sel), 32'd1);
            check(tag, "busy_resp", busyv(sel), 32'd0);
            check(tag, "rdata", rdv(sel) & mask, exp_word & mask);
         end
      end
      if (perturb) perturb_inputs();
      @(posedge clk); #1;
      check(tag, "ack_drop", ackv(sel), 32'd0);
      check(tag, "busy_idle", busyv(sel), 32'd0);
      if (!w) last_rd[sel] = exp_rd;
   endtask

   logic [31:0] ba_addr [2];
   logic [31:0] ba_data [2];

   initial begin
      reset = 1'b0;
      req1 = 1'b0; req2 = 1'b0; req3 = 1'b0;
      we = 1'b0; addr = '0; wdata = '0; be = '0;
      for (int i = 1; i <= 3; i++) last_rd[i] = '0;

      repeat (2) @(posedge clk);
      #1;
      for (int s = 1; s <= 3; s++) begin
         check("reset", "ack", ackv(s), 32'd0);
         check("reset", "busy", busyv(s), 32'd0);
         check("reset", "rdata", rdv(s), 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;

      // LATENCY=2: full word, partial lanes, empty mask
      txn(2, 2, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, '0, '1, 1'b0, "wr_full");
      txn(2, 2, 1'b0, 32'h10, '0, 4'b0000, 32'hDEADBEEF, '1, 1'b0, "rd_full");
      txn(2, 2, 1'b1, 32'h10, 32'h00000055, 4'b0001, '0, '1, 1'b0, "wr_lane0");
      txn(2, 2, 1'b0, 32'h10, '0, 4'b0000, 32'hDEADBE55, '1, 1'b0, "rd_lane0");
      // lane 1 of a write at 0x12 lands on byte 0x13
      txn(2, 2, 1'b1, 32'h12, 32'h0000AA00, 4'b0010, '0, '1, 1'b0, "wr_lane1");
      txn(2, 2, 1'b0, 32'h10, '0, 4'b0000, 32'hAAADBE55, '1, 1'b0, "rd_lane1");
      txn(2, 2, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, '0, '1, 1'b0, "wr_be0");
      txn(2, 2, 1'b0, 32'h10, '0, 4'b0000, 32'hAAADBE55, '1, 1'b0, "rd_be0");

      // wrap-around at the top of a 256-byte memory
      txn(2, 2, 1'b1, 32'hFF, 32'h44332211, 4'b1111, '0, '1, 1'b0, "wr_wrap");
      txn(2, 2, 1'b0, 32'h00, '0, 4'b0000, 32'h00443322, 32'h00FFFFFF, 1'b0, "rd_wrap0");
      txn(2, 2, 1'b0, 32'hFF, '0, 4'b0000, 32'h44332211, '1, 1'b0, "rd_wrapff");

      // inputs toggled every cycle while in flight
      txn(2, 2, 1'b1, 32'h30, 32'h01020304, 4'b1111, '0, '1, 1'b1, "wr_perturb");
      txn(2, 2, 1'b0, 32'h30, '0, 4'b0000, 32'h01020304, '1, 1'b0, "rd_after_pw");
      txn(2, 2, 1'b0, 32'h30, 32'h0BADF00D, 4'b1111, 32'h01020304, '1, 1'b1, "rd_perturb");
      txn(2, 2, 1'b0, 32'h30, '0, 4'b0000, 32'h01020304, '1, 1'b0, "rd_after_pr");
      txn(2, 2, 1'b0, 32'h10, '0, 4'b0000, 32'hAAADBE55, '1, 1'b0, "rd_untouched");

      // LATENCY=1 back-to-back with req held high
      ba_addr[0] = 32'h40; ba_data[0] = 32'h0A0B0C0D;
      ba_addr[1] = 32'h80; ba_data[1] = 32'h11223344;
      txn(1, 1, 1'b1, ba_addr[0], ba_data[0], 4'b1111, '0, '1, 1'b0, "b2b_init0");
      txn(1, 1, 1'b1, ba_addr[1], ba_data[1], 4'b1111, '0, '1, 1'b0, "b2b_init1");
      @(negedge clk);
      we = 1'b0; be = 4'b0000; addr = ba_addr[0];
      req1 = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         check("b2b", "ack", ackv(1), (c % 3 == 1) ? 32'd1 : 32'd0);
         check("b2b", "busy", busyv(1), (c % 3 == 0) ? 32'd1 : 32'd0);
         if (c % 3 == 1) check("b2b", "rdata", rdata1, ba_data[(c / 3) % 2]);
         if (c % 3 == 0) addr = ba_addr[((c / 3) + 1) % 2];
      end
      req1 = 1'b0;
      last_rd[1] = ba_data[1];

      // LATENCY=3: reset between E1 and E2 abandons a write
      txn(3, 3, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, '0, '1, 1'b0, "wr_prior");
      txn(3, 3, 1'b0, 32'h20, '0, 4'b0000, 32'hCAFEF00D, '1, 1'b0, "rd_prior");
      @(negedge clk);
      we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'b1111;
      req3 = 1'b1;
      @(posedge clk); #1;
      req3 = 1'b0;
      check("abort", "busy_e0", busyv(3), 32'd1);
      @(posedge clk); #2;
      check("abort", "busy_e1", busyv(3), 32'd1);
      reset = 1'b0;
      #1;
      check("abort", "ack_async", ackv(3), 32'd0);
      check("abort", "busy_async", busyv(3), 32'd0);
      check("abort", "rdata_async", rdata3, 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         check("abort", "no_ack", ackv(3), 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 1; i <= 3; i++) last_rd[i] = '0;
      txn(3, 3, 1'b0, 32'h20, '0, 4'b0000, 32'hCAFEF00D, '1, 1'b0, "rd_not_written");
      txn(2, 2, 1'b0, 32'h10, '0, 4'b0000, 32'hAAADBE55, '1, 1'b0, "rd_mem_kept");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
